// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - round-robin arbiter sharing the line memory between I-cache and D-cache
package const_pkg;
  localparam int PA_WIDTH   = 32;
  localparam int LINE_WIDTH = 64;
  localparam int ID_WIDTH   = 4;
endpackage

module mem_arbiter
  import const_pkg::*;
#(
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_ic_req,
  input  logic [PA_WIDTH-1:0]   i_ic_addr,
  output logic                  o_ic_gnt,
  output logic                  o_ic_rvalid,
  output logic [LINE_WIDTH-1:0] o_ic_rdata,
  input  logic                  i_ic_rready,
  input  logic                  i_dc_req,
  input  logic                  i_dc_write,
  input  logic [PA_WIDTH-1:0]   i_dc_addr,
  input  logic [LINE_WIDTH-1:0] i_dc_wdata,
  output logic                  o_dc_gnt,
  output logic                  o_dc_rvalid,
  output logic [LINE_WIDTH-1:0] o_dc_rdata,
  input  logic                  i_dc_rready,
  output logic                  o_mem_enable,
  output logic                  o_mem_write,
  output logic [PA_WIDTH-1:0]   o_mem_addr,
  output logic [LINE_WIDTH-1:0] o_mem_data,
  output logic [ID_WIDTH-1:0]   o_mem_id,
  output logic                  o_mem_ack,
  input  logic                  i_mem_valid,
  input  logic [LINE_WIDTH-1:0] i_mem_data,
  input  logic [ID_WIDTH-1:0]   i_mem_id,
  input  logic                  i_mem_full
);

  localparam int CW = $clog2(MAX_OUTSTANDING + 1);
  localparam int SW = ID_WIDTH - 1;
  localparam logic [CW-1:0] MAX_C = CW'(MAX_OUTSTANDING);

  logic [CW-1:0] ic_cnt, dc_cnt;
  logic [SW-1:0] ic_seq, dc_seq;
  logic          rr_ptr;        // 0 = I-cache has priority, 1 = D-cache
  logic          rsp_take, rsp_dc;
  logic          ic_ack, dc_ack;
  logic          ic_elig, dc_elig, pick_dc, can_issue;
  logic          ic_inc, ic_dec, dc_inc, dc_dec;
  logic          unused_id;

  // Only the source bit of the response tag is needed for routing.
  assign unused_id = ^i_mem_id[SW-1:0];

  // Response routing and ack; everything is forced low while reset is held.
  always_comb begin
    rsp_take    = rst && i_mem_valid && !i_mem_full;
    rsp_dc      = i_mem_id[ID_WIDTH-1];
    o_ic_rvalid = rsp_take && !rsp_dc;
    o_dc_rvalid = rsp_take && rsp_dc;
    o_ic_rdata  = o_ic_rvalid ? i_mem_data : '0;
    o_dc_rdata  = o_dc_rvalid ? i_mem_data : '0;
    ic_ack      = o_ic_rvalid && i_ic_rready;
    dc_ack      = o_dc_rvalid && i_dc_rready;
    o_mem_ack   = ic_ack || dc_ack;
  end

  // Eligibility, round-robin pick and issue mux. A same-cycle ack frees a
  // slot immediately so a blocked requester can be granted in that cycle.
  always_comb begin
    ic_elig   = i_ic_req && ((ic_cnt < MAX_C) || ic_ack);
    dc_elig   = i_dc_req && (i_dc_write || (dc_cnt < MAX_C) || dc_ack);
    can_issue = rst && !i_mem_full;
    pick_dc   = dc_elig && (!ic_elig || rr_ptr);
    o_dc_gnt  = can_issue && pick_dc;
    o_ic_gnt  = can_issue && ic_elig && !pick_dc;

    o_mem_enable = o_ic_gnt || o_dc_gnt;
    o_mem_write  = 1'b0;
    o_mem_addr   = '0;
    o_mem_data   = '0;
    o_mem_id     = '0;
    if (o_dc_gnt) begin
      o_mem_write = i_dc_write;
      o_mem_addr  = i_dc_addr;
      o_mem_data  = i_dc_write ? i_dc_wdata : '0;
      o_mem_id    = {1'b1, dc_seq};
    end else if (o_ic_gnt) begin
      o_mem_addr  = i_ic_addr;
      o_mem_id    = {1'b0, ic_seq};
    end

    ic_inc = o_ic_gnt;
    dc_inc = o_dc_gnt && !i_dc_write;
    ic_dec = ic_ack && (ic_cnt != '0);
    dc_dec = dc_ack && (dc_cnt != '0);
  end

  // Pointer, sequence and outstanding-read counter state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_ptr <= 1'b0;
      ic_seq <= '0;
      dc_seq <= '0;
      ic_cnt <= '0;
      dc_cnt <= '0;
    end else begin
      if (o_mem_enable) rr_ptr <= o_ic_gnt;
      if (o_ic_gnt) ic_seq <= ic_seq + 1'b1;
      if (o_dc_gnt) dc_seq <= dc_seq + 1'b1;
      if (ic_inc && !ic_dec)      ic_cnt <= ic_cnt + CW'(1);
      else if (!ic_inc && ic_dec) ic_cnt <= ic_cnt - CW'(1);
      if (dc_inc && !dc_dec)      dc_cnt <= dc_cnt + CW'(1);
      else if (!dc_inc && dc_dec) dc_cnt <= dc_cnt - CW'(1);
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed self-checking bench for mem_arbiter
module tb_mem_arbiter;
  localparam int PA = 32;
  localparam int LW = 64;
  localparam int IW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          ic_req, ic_gnt, ic_rvalid, ic_rready;
  logic [PA-1:0] ic_addr;
  logic [LW-1:0] ic_rdata;
  logic          dc_req, dc_write, dc_gnt, dc_rvalid, dc_rready;
  logic [PA-1:0] dc_addr;
  logic [LW-1:0] dc_wdata, dc_rdata;
  logic          mem_enable, mem_write, mem_ack, mem_valid, mem_full;
  logic [PA-1:0] mem_addr;
  logic [LW-1:0] mem_data, mem_rdata;
  logic [IW-1:0] mem_id, mem_rid;

  int checks = 0;
  int failures = 0;

  mem_arbiter dut (
    .clk(clk), .rst(rst),
    .i_ic_req(ic_req), .i_ic_addr(ic_addr), .o_ic_gnt(ic_gnt),
    .o_ic_rvalid(ic_rvalid), .o_ic_rdata(ic_rdata), .i_ic_rready(ic_rready),
    .i_dc_req(dc_req), .i_dc_write(dc_write), .i_dc_addr(dc_addr),
    .i_dc_wdata(dc_wdata), .o_dc_gnt(dc_gnt), .o_dc_rvalid(dc_rvalid),
    .o_dc_rdata(dc_rdata), .i_dc_rready(dc_rready),
    .o_mem_enable(mem_enable), .o_mem_write(mem_write), .o_mem_addr(mem_addr),
    .o_mem_data(mem_data), .o_mem_id(mem_id), .o_mem_ack(mem_ack),
    .i_mem_valid(mem_valid), .i_mem_data(mem_rdata), .i_mem_id(mem_rid),
    .i_mem_full(mem_full)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one full cycle; inputs change and outputs are sampled 1ns after the falling edge.
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  initial begin
    logic [IW-1:0] alt_ids [4];
    alt_ids = '{4'h0, 4'h8, 4'h1, 4'h9};
    rst = 1'b0;
    ic_req = 1'b1; ic_addr = 32'h100; ic_rready = 1'b0;
    dc_req = 1'b1; dc_write = 1'b0; dc_addr = 32'h200; dc_wdata = '0; dc_rready = 1'b0;
    mem_valid = 1'b0; mem_rdata = '0; mem_rid = '0; mem_full = 1'b0;
    tick();

    // reset state, requests already asserted
    chk("rst_ic_gnt", ic_gnt, 0);
    chk("rst_dc_gnt", dc_gnt, 0);
    chk("rst_enable", mem_enable, 0);
    chk("rst_id", mem_id, 0);
    rst = 1'b1;
    #1;

    // alternating grants with both caches reading
    for (int i = 0; i < 4; i++) begin
      chk("alt_ic_gnt", ic_gnt, (i % 2 == 0));
      chk("alt_dc_gnt", dc_gnt, (i % 2 == 1));
      chk("alt_id", mem_id, alt_ids[i]);
      chk("alt_addr", mem_addr, (i % 2 == 0) ? 32'h100 : 32'h200);
      tick();
    end

    // memory full: no grant, no ack even with a response pending
    mem_full = 1'b1; mem_valid = 1'b1; mem_rid = 4'h0; ic_rready = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) begin
      chk("full_ic_gnt", ic_gnt, 0);
      chk("full_dc_gnt", dc_gnt, 0);
      chk("full_enable", mem_enable, 0);
      chk("full_ack", mem_ack, 0);
      chk("full_ic_rvalid", ic_rvalid, 0);
      tick();
    end
    mem_full = 1'b0; mem_valid = 1'b0; ic_rready = 1'b0;
    #1;
    chk("post_full_ic_gnt", ic_gnt, 1);
    chk("post_full_dc_gnt", dc_gnt, 0);
    chk("post_full_id", mem_id, 4'h2);
    tick();
    ic_req = 1'b0; dc_req = 1'b0;

    // D-cache response held by rready=0 for two cycles
    mem_valid = 1'b1; mem_rid = 4'h9; mem_rdata = 64'hDEAD_BEEF_0000_0009;
    #1;
    for (int i = 0; i < 2; i++) begin
      chk("hold_dc_rvalid", dc_rvalid, 1);
      chk("hold_dc_rdata", dc_rdata, 64'hDEAD_BEEF_0000_0009);
      chk("hold_ic_rvalid", ic_rvalid, 0);
      chk("hold_ack", mem_ack, 0);
      tick();
    end
    dc_rready = 1'b1;
    #1;
    chk("hold_ack3", mem_ack, 1);
    tick();
    mem_valid = 1'b0; dc_rready = 1'b0;

    // D-cache write beats I-cache read while the pointer selects D-cache
    ic_req = 1'b1; dc_req = 1'b1; dc_write = 1'b1; dc_addr = 32'h40;
    dc_wdata = 64'h0123_4567_89AB_CDEF;
    #1;
    chk("wr_dc_gnt", dc_gnt, 1);
    chk("wr_ic_gnt", ic_gnt, 0);
    chk("wr_write", mem_write, 1);
    chk("wr_addr", mem_addr, 32'h40);
    chk("wr_data", mem_data, 64'h0123_4567_89AB_CDEF);
    chk("wr_id", mem_id, 4'hA);
    tick();
    dc_req = 1'b0; dc_write = 1'b0;
    #1;
    chk("wr_next_ic_gnt", ic_gnt, 1);
    chk("wr_next_write", mem_write, 0);
    chk("wr_next_data", mem_data, 0);
    chk("wr_next_id", mem_id, 4'h3);
    tick();
    ic_req = 1'b0;

    // D-cache has one read left outstanding: three more reads fit, the fourth blocks
    dc_req = 1'b1; dc_addr = 32'h300;
    #1;
    for (int i = 0; i < 3; i++) begin
      chk("dc_fill_gnt", dc_gnt, 1);
      chk("dc_fill_id", mem_id, 4'hB + 4'(i));
      tick();
    end
    chk("dc_limit_gnt", dc_gnt, 0);
    chk("dc_limit_enable", mem_enable, 0);

    // I-cache at its limit; an acked response lets it through in the same cycle
    ic_req = 1'b1;
    #1;
    chk("ic_limit_gnt", ic_gnt, 0);
    mem_valid = 1'b1; mem_rid = 4'h0; ic_rready = 1'b1; mem_rdata = 64'h1111;
    #1;
    chk("ic_free_rvalid", ic_rvalid, 1);
    chk("ic_free_ack", mem_ack, 1);
    chk("ic_free_gnt", ic_gnt, 1);
    chk("ic_free_id", mem_id, 4'h4);
    tick();
    mem_valid = 1'b0;
    #1;
    chk("ic_relimit_gnt", ic_gnt, 0);
    ic_req = 1'b0; dc_req = 1'b0;
    mem_valid = 1'b1;
    tick();
    mem_valid = 1'b0;

    // asynchronous reset mid-cycle with I-cache holding three reads
    ic_req = 1'b1; dc_req = 1'b1;
    mem_valid = 1'b1; mem_rid = 4'h0; ic_rready = 1'b1;
    #1;
    chk("pre_rst_ic_gnt", ic_gnt, 1);
    chk("pre_rst_ack", mem_ack, 1);
    #1;
    rst = 1'b0;
    #1;
    chk("arst_ic_gnt", ic_gnt, 0);
    chk("arst_dc_gnt", dc_gnt, 0);
    chk("arst_enable", mem_enable, 0);
    chk("arst_ack", mem_ack, 0);
    chk("arst_rvalid", ic_rvalid, 0);
    chk("arst_addr", mem_addr, 0);
    ic_req = 1'b0; dc_req = 1'b0; mem_valid = 1'b0;
    tick();
    rst = 1'b1;

    // spurious I-cache response with nothing outstanding: counter must stay at 0
    mem_valid = 1'b1; mem_rid = 4'h0; ic_rready = 1'b1;
    #1;
    chk("spur_ack", mem_ack, 1);
    tick();
    mem_valid = 1'b0;

    // five back-to-back I-cache reads: four granted from id 0, fifth held
    ic_req = 1'b1; ic_addr = 32'h500;
    #1;
    for (int i = 0; i < 4; i++) begin
      chk("ic5_gnt", ic_gnt, 1);
      chk("ic5_id", mem_id, 4'(i));
      tick();
    end
    for (int i = 0; i < 2; i++) begin
      chk("ic5_held", ic_gnt, 0);
      tick();
    end
    mem_valid = 1'b1; mem_rid = 4'h0;
    #1;
    chk("ic5_release_gnt", ic_gnt, 1);
    chk("ic5_release_id", mem_id, 4'h4);
    chk("ic5_release_ack", mem_ack, 1);
    tick();
    ic_req = 1'b0; mem_valid = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
